// File: rtl/serial_word_collector_pkg.sv
// Shared types and width helpers for the serial word collector.
package cad_pkg;

  typedef logic [0:0] state_t;

  localparam state_t COLLECT = 1'b0;
  localparam state_t HOLD    = 1'b1;

  // A bit index counter needs at least one flop, even for single-bit words.
  function automatic int CNT_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_collector_counter.sv
// Modulo-N up-counter with enable and synchronous clear; flags the last index.
module bit_index_counter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Bit-serial to N-bit word collector with running all-ones / any-one flags.
module serial_word_collector
  import cad_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_word,
  output logic         out_all_ones,
  output logic         out_any_one
);

  localparam int CW = CNT_W(N);

  state_t          state;
  logic            rdy;
  logic            and_acc;
  logic            or_acc;
  logic [N-1:0]    word;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;

  assign accept = in_valid & in_ready;

  bit_index_counter #(
    .N (N),
    .W (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .en   (accept & ~flush),
    .cnt  (cnt),
    .last (last)
  );

  // rdy keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      rdy     <= 1'b0;
      word    <= '0;
      and_acc <= 1'b1;
      or_acc  <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (flush) begin
        state   <= COLLECT;
        word    <= '0;
        and_acc <= 1'b1;
        or_acc  <= 1'b0;
      end else if (state == COLLECT) begin
        if (accept) begin
          word    <= word | (N'(in_bit) << cnt);
          and_acc <= and_acc & in_bit;
          or_acc  <= or_acc | in_bit;
          if (last) state <= HOLD;
        end
      end else if (out_ready) begin
        state   <= COLLECT;
        word    <= '0;
        and_acc <= 1'b1;
        or_acc  <= 1'b0;
      end
    end
  end

  // Outputs decode from state and registers only; nothing is shown outside HOLD.
  assign in_ready     = rdy & (state == COLLECT);
  assign out_valid    = (state == HOLD);
  assign out_word     = out_valid ? word : '0;
  assign out_all_ones = out_valid & and_acc;
  assign out_any_one  = out_valid & or_acc;

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Bit-serial receiver that assembles N incoming bits into an N-bit parallel word and reports its AND-reduction (all-ones) and OR-reduction (any-one) flags. It is the serial-input counterpart of the parallel N-bit AND-reduction tree, and feeds that tree or any consumer that needs a full word plus a reduced flag. Both flags are accumulated bit by bit as the word arrives, so they are valid in the same cycle the word is presented.

## Interface
- N, default 5: word width and bits per word; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort: discards the partial or held word.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  collector accepts a bit this cycle.
- out_valid  output  1  out_word and flags are valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_word  output  N  assembled word; the first bit received lands in bit 0.
- out_all_ones  output  1  AND of all N bits of out_word.
- out_any_one  output  1  OR of all N bits of out_word.

## Operation
- FSM states:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- A bit is accepted on a cycle with in_valid & in_ready. When accepted:
  - in_bit is written to word[cnt].
  - and_acc <= and_acc & in_bit.
  - or_acc <= or_acc | in_bit.
  - cnt increments.
- Accumulator initial values are and_acc=1 and or_acc=0. They are re-initialised on reset, flush and word handoff.
- COLLECT -> HOLD occurs on acceptance of the Nth bit (cnt == N-1). cnt returns to 0.
- HOLD -> COLLECT occurs on out_valid & out_ready. The word register and accumulators are cleared on this edge.
- In HOLD, out_word, out_all_ones and out_any_one stay stable until the handoff.
- in_valid while in_ready=0 is ignored; the bit is not consumed.
- flush has priority over all other inputs:
  - Next state is COLLECT, cnt=0, word=0, accumulators initialised.
  - A held word is dropped without a handoff.
- Counter width is $clog2(N) bits, with a minimum of 1. It never exceeds N-1.
- N=1: every accepted bit goes directly to HOLD. Flags equal the bit.
- Reset values: in_ready=0 during reset, then 1 from the first cycle after deassertion. out_valid=0, out_word=0, out_all_ones=0, out_any_one=0.
- out_all_ones is gated by out_valid, so it reads 0 whenever out_valid=0.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Latency: out_valid rises on the clock edge that accepts the Nth bit.
- Peak throughput is one word per N+1 cycles, because in_ready is low for at least one cycle in HOLD.
- Simultaneous out_ready and flush in HOLD: flush wins, and the handoff is not counted.
- Reset asserted mid-word or mid-HOLD: all state clears immediately and asynchronously. No partial word is ever presented afterwards.
- Release of rst is synchronised externally; the block takes no special action on deassertion.

## Structure
- Shared package (cad_pkg):
  - state typedef: COLLECT=1'b0, HOLD=1'b1.
  - width helper function CNT_W(N) = max(1, $clog2(N)).
- One sub-module, bit_index_counter:
  - Parameterised modulo-N up-counter with enable and synchronous clear.
  - Outputs the count and a terminal flag (cnt == N-1).
- The top-level module holds the FSM, the word register and the two accumulator flops.

## Test plan
- N=5, send 1,1,1,1,1 with continuous valid, out_ready=1 -> out_valid high one cycle after the 5th bit; out_word=5'b11111, all_ones=1, any_one=1; in_ready low for exactly 1 cycle.
- N=5, send 1,0,1,1,0 with out_ready held 0 for 3 cycles -> out_word=5'b01101, all_ones=0, any_one=1; outputs stable while out_ready=0; extra in_valid pulses during HOLD are not consumed.
- N=5, send 0,0,0,0,0 -> out_word=0, all_ones=0, any_one=0; back-to-back second word 1,1,1,1,1 -> second output is 5'b11111, with no carry-over of the accumulators.
- N=5, flush after 3 bits, then send 1,1,1,1,1 -> only one word out, 5'b11111. Also flush in HOLD together with out_ready=1 -> out_valid drops, no handoff.
- Assert rst asynchronously mid-word (between clock edges) -> all outputs 0 immediately. After release, a fresh 5-bit word is assembled correctly.
- N=1, bits 1 then 0 -> two words: out_word=1 with all_ones=1, then out_word=0 with all_ones=0.
